// File: rtl/uart_mem_loader.sv
// UART (8N1) hex-digit loader: assembles DIGITS ASCII hex characters into one
// word and issues a single-cycle write strobe toward the display memory.
module uart_mem_loader #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DIGITS       = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rx,
    output logic                  we,
    output logic [4*DIGITS-1:0]   mem_in,
    output logic [3:0]            count,
    output logic                  busy,
    output logic                  err,
    output logic [1:0]            dbg_state
);

    localparam int W     = 4 * DIGITS;
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF       = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] LAST       = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0]       LAST_DIGIT = 4'(DIGITS - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t           state, state_next;
    logic             rx_s1, rx_s2, rx_prev;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       rx_byte;
    logic             byte_valid;
    logic [W-1:0]     word;
    logic             fall, tick_half, tick_full, stop_tick, baud_clr;
    logic             is_num, is_upper, is_lower, is_eol;
    logic [3:0]       nibble;
    logic [W-1:0]     shifted;

    assign fall      = rx_prev & ~rx_s2;
    assign tick_half = (baud_cnt == HALF);
    assign tick_full = (baud_cnt == LAST);
    assign stop_tick = (state == STOP) && tick_full;
    assign baud_clr  = (state == IDLE) || ((state == START) ? tick_half : tick_full);
    assign busy      = (state != IDLE);
    assign dbg_state = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (fall) state_next = START;
            START: if (tick_half) state_next = rx_s2 ? IDLE : DATA;
            DATA:  if (tick_full && bit_cnt == 3'd7) state_next = STOP;
            STOP:  if (tick_full) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The offsets 0x30/0x37/0x57 only matter modulo 16, so the subtraction is
    // done on the low nibble alone (0 for digits, 7 for either letter case).
    always_comb begin
        is_num   = (rx_byte >= 8'h30) && (rx_byte <= 8'h39);
        is_upper = (rx_byte >= 8'h41) && (rx_byte <= 8'h46);
        is_lower = (rx_byte >= 8'h61) && (rx_byte <= 8'h66);
        is_eol   = (rx_byte == 8'h0D) || (rx_byte == 8'h0A);
        nibble   = rx_byte[3:0] - (is_num ? 4'h0 : 4'h7);
    end

    assign shifted = {word[W-5:0], nibble};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_s1      <= 1'b1;
            rx_s2      <= 1'b1;
            rx_prev    <= 1'b1;
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            rx_byte    <= '0;
            byte_valid <= 1'b0;
            word       <= '0;
            mem_in     <= '0;
            count      <= '0;
            we         <= 1'b0;
            err        <= 1'b0;
        end else begin
            rx_s1      <= rx;
            rx_s2      <= rx_s1;
            rx_prev    <= rx_s2;
            baud_cnt   <= baud_clr ? '0 : baud_cnt + 1'b1;
            byte_valid <= stop_tick && rx_s2;
            we         <= 1'b0;
            err        <= 1'b0;

            if (state == IDLE) begin
                bit_cnt <= '0;
            end else if (state == DATA && tick_full) begin
                rx_byte <= {rx_s2, rx_byte[7:1]};
                bit_cnt <= bit_cnt + 3'd1;
            end

            if (stop_tick && !rx_s2) begin
                err   <= 1'b1;
                count <= '0;
            end else if (byte_valid) begin
                if (is_num || is_upper || is_lower) begin
                    word <= shifted;
                    if (count == LAST_DIGIT) begin
                        mem_in <= shifted;
                        we     <= 1'b1;
                        count  <= '0;
                    end else begin
                        count <= count + 4'd1;
                    end
                end else if (is_eol) begin
                    count <= '0;
                end else begin
                    // Bad characters keep the shift register; new digits overwrite it.
                    err   <= 1'b1;
                    count <= '0;
                end
            end
        end
    end

endmodule

// File: doc/uart_mem_loader.md
# uart_mem_loader

Serial loader that fills the 40-bit display memory from a host terminal, the write-side counterpart of the rolling display. It receives 8N1 UART bytes and decodes ASCII hex digits. It assembles ten digits into one 40-bit word and issues a single-cycle write (`we`, `mem_in`) to the `Memory` block. It sits beside `EditMemory` in the top level, with the two write sources muxed by mode.

## Interface

Parameters:
- `CLKS_PER_BIT`, default 434: clock cycles per UART bit (50 MHz / 115200). Minimum 4.
- `DIGITS`, default 10: hex digits per word. Word width is `4*DIGITS`.

Ports:
- `clk`, input, 1: single system clock.
- `reset`, input, 1: asynchronous, active-high reset.
- `rx`, input, 1: raw UART line, idle high. It is asynchronous and is synchronised internally by a 2-flop chain.
- `we`, output, 1: one-cycle write strobe to `Memory`.
- `mem_in`, output, `4*DIGITS`: assembled word. It is registered and held stable until the next write.
- `count`, output, 4: digits accepted in the current word (0..`DIGITS-1`).
- `busy`, output, 1: high while the receiver FSM is not IDLE.
- `err`, output, 1: one-cycle pulse on a framing error or an illegal character.

## Operation

Reset state:
- All outputs are 0.
- The FSM is in IDLE.
- The shift register is cleared.

Receiver FSM:
- **IDLE**: on a synchronised falling edge of `rx`, go to START and clear the bit counter.
- **START**: wait `CLKS_PER_BIT/2` cycles, then sample `rx`.
  - If `rx` is 1 (glitch), return to IDLE silently.
  - Otherwise go to DATA.
- **DATA**: sample every `CLKS_PER_BIT` cycles, 8 bits, LSB first, into the byte register. After bit 7, go to STOP.
- **STOP**: sample after `CLKS_PER_BIT` cycles.
  - If `rx` is 1, raise the internal `byte_valid` for one cycle.
  - If `rx` is 0, this is a framing error: pulse `err`, discard the byte, and set `count` to 0.
  - In both cases, return to IDLE.

Character decoding, applied on `byte_valid`:
- `'0'`–`'9'`, `'A'`–`'F'`, `'a'`–`'f'` are valid digits.
  - The word register shifts left 4 bits and the new nibble enters at bits [3:0]. The first digit typed therefore ends up in the top nibble [39:36].
  - `count` increments.
- CR (0x0D) or LF (0x0A): abort the partial word. `count` goes to 0, no write and no `err`.
- Any other byte: pulse `err` and set `count` to 0. The shift register is not cleared; it is overwritten by the next digits.
- On the `DIGITS`-th valid digit:
  - Copy the shifted word into `mem_in`.
  - Pulse `we` for one cycle.
  - Set `count` to 0. `count` never shows the value `DIGITS`.

Arithmetic and width rules:
- The digit value is `byte-8'h30` for digits, `byte-8'h37` for uppercase, and `byte-8'h57` for lowercase, truncated to 4 bits.
- The baud counter has width `$clog2(CLKS_PER_BIT)` and wraps to 0 at `CLKS_PER_BIT-1`.

Reset:
- A reset mid-byte or mid-word returns to the reset state within the same edge, because reset is asynchronous.
- A partially received byte is lost. No `we` or `err` is produced by reset.

## Timing

- The input synchroniser adds 2 cycles of latency on `rx`.
- `byte_valid` is asserted the cycle after the stop-bit sample edge.
- `we`/`mem_in` are valid the cycle after `byte_valid`. Total latency is 2 cycles from the stop sample.
- `err` is asserted:
  - the cycle after the stop sample, for a framing error;
  - the cycle after `byte_valid`, for an illegal character.
- `we` and `err` are never high in the same cycle.
- Back-to-back bytes are supported. A start edge detected in the cycle IDLE is re-entered is accepted, so there is no dead time beyond the stop sample.
- `busy` rises the cycle after the falling edge is detected and falls on return to IDLE.

## Test plan

Run all scenarios with `CLKS_PER_BIT=4`.

1. **Reset values**: assert `reset` mid-frame, with `rx` driven low. Required: `we=0`, `err=0`, `busy=0`, `count=0`, `mem_in=0` immediately, with no clock edge. After release, with `rx` idle, the outputs stay at those values.
2. **Full word**: send "0123456789". Required: exactly one `we` pulse, 2 cycles after the 10th stop sample, with `mem_in=40'h0123456789`. `count` steps 1..9 then returns to 0. `mem_in` holds until the next word.
3. **Case mixing**: send "aBcDeF0a1B". Required: `mem_in=40'hABCDEF0A1B`, one `we` pulse.
4. **Abort and illegal character**:
   - Send "12345", then CR. Required: `count=0`, no `we`, no `err`.
   - Then send "12G". Required: one `err` pulse on 'G' and `count=0`.
   - Then send "FFFFFFFFFF". Required: `mem_in=40'hFFFFFFFFFF`.
5. **Framing error**: send a digit byte with the stop bit held at 0, then a 1 µs idle, then ten '7's. Required: one `err` on the bad byte, `count` cleared, then `mem_in=40'h7777777777`.
6. **Glitch and back-to-back**:
   - A 1-cycle low pulse on `rx` causes no byte, no `err`, and `busy` returns to 0.
   - Twenty digits sent with zero idle gap produce two `we` pulses with the correct words.
